// File: rtl/led_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_pkg : mode encodings, pattern FSM states and default prescaler count   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package led_pkg;

    localparam logic [1:0] MODE_LEFT   = 2'b00;
    localparam logic [1:0] MODE_RIGHT  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

    localparam int unsigned DEFAULT_CNT_MAX = 32'd24_999_999;

    typedef enum logic [2:0] {
        S_LEFT   = 3'd0,
        S_RIGHT  = 3'd1,
        S_BNC_UP = 3'd2,
        S_BNC_DN = 3'd3,
        S_BLINK  = 3'd4
    } led_state_t;

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_flow_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_flow_ctrl_if : mode/pause control and LED drive bundle                 |
// | Optional duty input when LED_FLOW_DIM_EN is defined.  Revision: 1.0        |
// +----------------------------------------------------------------------------+
interface led_flow_ctrl_if #(
    parameter int LED_NUM = 8
);
    logic [1:0]         mode;
    logic               mode_vld;
    logic               pause;
    logic [LED_NUM-1:0] led_out;
    logic               step_pulse;
`ifdef LED_FLOW_DIM_EN
    logic [3:0]         duty;

    modport master (output mode, output mode_vld, output pause, output duty,
                    input  led_out, input step_pulse);
    modport slave  (input  mode, input  mode_vld, input  pause, input  duty,
                    output led_out, output step_pulse);
`else
    modport master (output mode, output mode_vld, output pause,
                    input  led_out, input step_pulse);
    modport slave  (input  mode, input  mode_vld, input  pause,
                    output led_out, output step_pulse);
`endif
endinterface : led_flow_ctrl_if
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_tick_gen : step prescaler, one tick every CNT_MAX+1 unpaused clocks    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module led_tick_gen #(
    parameter int unsigned CNT_MAX = 32'd24_999_999
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr,
    input  wire logic pause,
    output logic      tick
);
    localparam int CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_TOP) && !pause;

    // A mode load restarts the step period even while paused.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!pause) begin
            cnt_d = (cnt_q == CNT_TOP) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : led_tick_gen
`default_nettype wire

// File: rtl/led_flow_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_flow_ctrl : running-LED controller (left/right/bounce/blink, pause)    |
// | LED_FLOW_DIM_EN adds 16-step PWM dimming via duty.  Revision: 1.0          |
// +----------------------------------------------------------------------------+
module led_flow_ctrl
    import led_pkg::*;
#(
    parameter int          LED_NUM    = 8,
    parameter int unsigned CNT_MAX    = DEFAULT_CNT_MAX,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  wire logic      sys_clk,
    input  wire logic      sys_rst_n,
    led_flow_ctrl_if.slave bus
);
    localparam logic [LED_NUM-1:0] ONE_HOT0 = LED_NUM'(1);

    function automatic logic [LED_NUM-1:0] to_pins(input logic [LED_NUM-1:0] lit);
        return ACTIVE_LOW ? ~lit : lit;
    endfunction

    led_state_t         state_q, state_d;
    logic [LED_NUM-1:0] pattern_q, pattern_d;
    logic [LED_NUM-1:0] led_q, led_d;
    logic [LED_NUM-1:0] lit;
    logic               step_q, step_d;
    logic               tick;
    logic [LED_NUM-1:0] rot_l, rot_r, shl, shr;

    led_tick_gen #(
        .CNT_MAX (CNT_MAX)
    ) u_tick_gen (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   (bus.mode_vld),
        .pause (bus.pause),
        .tick  (tick)
    );

    // A single LED cannot move, so every shift degenerates to a hold.
    generate
        if (LED_NUM > 1) begin : g_multi
            assign rot_l = {pattern_q[LED_NUM-2:0], pattern_q[LED_NUM-1]};
            assign rot_r = {pattern_q[0], pattern_q[LED_NUM-1:1]};
            assign shl   = pattern_q << 1;
            assign shr   = pattern_q >> 1;
        end else begin : g_single
            assign rot_l = pattern_q;
            assign rot_r = pattern_q;
            assign shl   = pattern_q;
            assign shr   = pattern_q;
        end
    endgenerate

`ifdef LED_FLOW_DIM_EN
    logic [3:0] pwm_cnt_q, pwm_cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        step_d    = 1'b0;
        if (bus.mode_vld) begin
            pattern_d = ONE_HOT0;
            case (bus.mode)
                MODE_LEFT:   state_d = S_LEFT;
                MODE_RIGHT:  state_d = S_RIGHT;
                MODE_BOUNCE: state_d = S_BNC_UP;
                default: begin
                    state_d   = S_BLINK;
                    pattern_d = '1;
                end
            endcase
        end else if (tick) begin
            step_d = 1'b1;
            case (state_q)
                S_LEFT:  pattern_d = rot_l;
                S_RIGHT: pattern_d = rot_r;
                S_BNC_UP: begin
                    pattern_d = shl;
                    if ((LED_NUM > 1) && shl[LED_NUM-1]) state_d = S_BNC_DN;
                end
                S_BNC_DN: begin
                    pattern_d = shr;
                    if (shr[0]) state_d = S_BNC_UP;
                end
                S_BLINK: pattern_d = ~pattern_q;
                default: begin
                    state_d   = S_LEFT;
                    pattern_d = ONE_HOT0;
                end
            endcase
        end

        lit = pattern_d;
`ifdef LED_FLOW_DIM_EN
        pwm_cnt_d = pwm_cnt_q + 4'd1;
        if (pwm_cnt_d >= bus.duty) lit = '0;
`endif
        led_d = to_pins(lit);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= S_LEFT;
            pattern_q <= ONE_HOT0;
            step_q    <= 1'b0;
            led_q     <= to_pins(ONE_HOT0);
`ifdef LED_FLOW_DIM_EN
            pwm_cnt_q <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            step_q    <= step_d;
            led_q     <= led_d;
`ifdef LED_FLOW_DIM_EN
            pwm_cnt_q <= pwm_cnt_d;
`endif
        end
    end

    assign bus.led_out    = led_q;
    assign bus.step_pulse = step_q;

endmodule : led_flow_ctrl
`default_nettype wire

// File: tb/tb_led_flow_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_led_flow_ctrl : randomized scoreboard bench against a position model    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_led_flow_ctrl;
    import led_pkg::*;

    localparam int N  = 8;
    localparam int CM = 24;
    localparam bit AL = 1'b1;

    typedef struct {
        logic [N-1:0] led;
        int           cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_flow_ctrl_if #(.LED_NUM(N)) bus ();

    led_flow_ctrl #(
        .LED_NUM    (N),
        .CNT_MAX    (CM),
        .ACTIVE_LOW (AL)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus.slave)
    );

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   mcnt  = 0;
    int   k     = 0;
    int   mpwm  = 0;
    bit   mrst  = 1'b1;
    bit   mon_en = 1'b0;
    logic [1:0] mmode = MODE_LEFT;
    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Lit pattern derived from mode and the number of steps since the last load.
    function automatic logic [N-1:0] ref_pat(input logic [1:0] md, input int kk);
        logic [N-1:0] p;
        int per, r, pos;
        p = '0;
        case (md)
            MODE_LEFT:  p[kk % N] = 1'b1;
            MODE_RIGHT: p[(N - (kk % N)) % N] = 1'b1;
            MODE_BOUNCE: begin
                if (N == 1) begin
                    pos = 0;
                end else begin
                    per = 2 * (N - 1);
                    r   = kk % per;
                    pos = (r <= N - 1) ? r : per - r;
                end
                p[pos] = 1'b1;
            end
            default: p = (kk % 2 == 0) ? '1 : '0;
        endcase
        return p;
    endfunction

    function automatic logic [N-1:0] led_of(input logic [N-1:0] pat, input int pwm);
        logic [N-1:0] lit;
        lit = pat;
`ifdef LED_FLOW_DIM_EN
        if (!(pwm < int'(bus.duty))) lit = '0;
`else
        if (pwm < 0) lit = '0;
`endif
        return AL ? ~lit : lit;
    endfunction

    function automatic logic [N-1:0] exp_now();
        logic [N-1:0] one;
        one = N'(1);
        if (mrst) return AL ? ~one : one;
        return led_of(ref_pat(mmode, k), mpwm);
    endfunction

    // Reference model: advances on every clock edge from the applied inputs.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            mmode = MODE_LEFT; k = 0; mcnt = 0; mpwm = 0; mrst = 1'b1;
        end else begin
            mrst = 1'b0;
            mpwm = (mpwm + 1) % 16;
            if (bus.mode_vld) begin
                mmode = bus.mode; k = 0; mcnt = 0;
            end else if (!bus.pause) begin
                if (mcnt == CM) begin
                    mcnt = 0;
                    k++;
                    q.push_back('{led: led_of(ref_pat(mmode, k), mpwm), cyc: cyc});
                end else begin
                    mcnt++;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every step strobe, checks the hold value otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (bus.step_pulse === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_step", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("step_led", 32'(bus.led_out), 32'(e.led));
                    check("step_cycle", cyc, e.cyc);
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                check("missing_step", 32'(bus.step_pulse), 32'd1);
            end
            check("led_out", 32'(bus.led_out), 32'(exp_now()));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [1:0] md);
        @(negedge clk);
        bus.mode = md; bus.mode_vld = 1'b1;
        @(negedge clk);
        bus.mode_vld = 1'b0;
    endtask

    task automatic wait_cnt(input int target);
        int t;
        t = 0;
        while (mcnt != target && t < 4 * (CM + 1)) begin
            @(negedge clk);
            t++;
        end
        check("wait_cnt_timeout", 32'(mcnt), 32'(target));
    endtask

    task automatic load_on_tick(input logic [1:0] md);
        bus.pause = 1'b0;
        @(negedge clk);
        wait_cnt(CM);
        bus.mode = md; bus.mode_vld = 1'b1;
        @(negedge clk);
        bus.mode_vld = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        bus.mode = MODE_LEFT; bus.mode_vld = 1'b0; bus.pause = 1'b0;
`ifdef LED_FLOW_DIM_EN
        bus.duty = 4'd4;
`endif
        #20;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        check("reset_step_pulse", 32'(bus.step_pulse), 32'd0);
`ifndef LED_FLOW_DIM_EN
        check("reset_led", 32'(bus.led_out), 32'hFE);
`endif
        cycles(25 * 9);
        load(MODE_RIGHT);
        cycles(25 * 3);
        load(MODE_BOUNCE);
        cycles(350 + 50);
        load(MODE_BLINK);
        cycles(80);

        load(MODE_LEFT);
        wait_cnt(10);
        bus.pause = 1'b1;
        cycles(100);
        bus.pause = 1'b0;
        cycles(30);
        bus.pause = 1'b1;
        cycles(5);
        load(MODE_BLINK);
        cycles(20);
        bus.pause = 1'b0;
        cycles(40);

        load_on_tick(MODE_BOUNCE);
        cycles(100);
        pulse_reset();
        cycles(30);

        repeat (60) begin
            cycles($urandom_range(1, 60));
            r = $urandom_range(0, 9);
            if (r < 4)       load(2'($urandom_range(0, 3)));
            else if (r < 6)  bus.pause = ~bus.pause;
            else if (r == 6) pulse_reset();
            else if (r == 7) load_on_tick(2'($urandom_range(0, 3)));
`ifdef LED_FLOW_DIM_EN
            else if (r == 8) bus.duty = 4'($urandom_range(0, 15));
`endif
        end

        bus.pause = 1'b0;
        cycles(60);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_led_flow_ctrl
`default_nettype wire

// File: doc/led_flow_ctrl.md
Name: led_flow_ctrl

Overview:
- Parametrised running-LED ("water LED") controller; successor to the fixed 8-LED single-direction flow block.
- Generalised in LED count and step period; adds four run-time modes (rotate left, rotate right, ping-pong, blink), pause, and a step strobe.
- Sits directly on the board LED pins; mode/pause come from key-debounce logic upstream.

Parameters:
- LED_NUM, 8, number of LEDs (>=1).
- CNT_MAX, 27'd24_999_999, prescaler terminal count; one step every CNT_MAX+1 clocks.
- ACTIVE_LOW, 1, 1 = led_out is inverted (LED lit when 0); 0 = lit when 1.
- localparam CNT_W = $clog2(CNT_MAX+1).

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- mode  in  2  requested mode: 00 LEFT, 01 RIGHT, 10 BOUNCE, 11 BLINK.
- mode_vld  in  1  one-cycle strobe; loads mode.
- pause  in  1  level; 1 freezes prescaler and pattern.
- led_out  out  LED_NUM  registered LED drive.
- step_pulse  out  1  one-cycle high on every pattern update.

Behaviour:
- Reset (sys_rst_n=0 at a sys_clk edge): cnt=0, pattern=one-hot bit0, state=S_LEFT, step_pulse=0, led_out = ACTIVE_LOW ? ~1 : 1 (LED_NUM=8, ACTIVE_LOW=1: 8'hFE). Reset asserted mid-operation restores these values on the same edge.
- Prescaler: cnt counts 0..CNT_MAX, wraps to 0. tick = (cnt==CNT_MAX) && !pause. While pause=1, cnt holds.
- On tick: pattern updates on the same edge, step_pulse=1 for that cycle, and led_out reflects the new pattern in the same registered cycle. Latency from cnt reaching CNT_MAX to the led_out change is one clock.
- FSM states: S_LEFT, S_RIGHT, S_BNC_UP, S_BNC_DN, S_BLINK.
  - S_LEFT: rotate left, bit LED_NUM-1 wraps to bit0.
  - S_RIGHT: rotate right, bit0 wraps to bit LED_NUM-1.
  - S_BNC_UP: shift left. When the new pattern reaches bit LED_NUM-1, go to S_BNC_DN.
  - S_BNC_DN: shift right. When the new pattern reaches bit0, go to S_BNC_UP.
  - End positions appear once per pass. Period is 2*(LED_NUM-1) steps.
  - S_BLINK: pattern toggles between all-ones and all-zeros. On entry, pattern = all-ones.
- mode_vld=1: on the next edge, enter the state for mode (10 -> S_BNC_UP), cnt=0, pattern=bit0 (all-ones for BLINK), step_pulse=0.
  - Applies even when pause=1.
  - If mode_vld coincides with tick, the mode load wins and the tick is discarded.
  - Reloading the current mode restarts it.
- LED_NUM=1: LEFT, RIGHT and BOUNCE hold bit0 lit; step_pulse still fires. BOUNCE stays in S_BNC_UP.
- Simultaneous reset and any input: reset wins.

Optional Feature:
- Macro: LED_FLOW_DIM_EN.
- Defined:
  - Adds input port duty[3:0] and a free-running 4-bit pwm_cnt.
  - A lit LED is driven lit only while pwm_cnt < duty. duty=0 gives fully dark; duty=15 gives 15/16 brightness.
  - pwm_cnt resets to 0 and is unaffected by pause.
- Undefined: no duty port; lit LEDs are driven continuously.

Decomposition:
- Package led_pkg: mode encodings (MODE_LEFT/RIGHT/BOUNCE/BLINK), FSM state enum, default CNT_MAX.
- One sub-module, led_tick_gen: prescaler with pause, outputs tick. The pattern FSM stays in led_flow_ctrl.

Test Plan (LED_NUM=8, CNT_MAX=24, ACTIVE_LOW=1, 10 ns clock, reset low for 20 ns):
1. Reset release, mode LEFT -> led_out=8'hFE. Then FD, FB, ... 7F, FE; one step per 25 clocks, step_pulse width 1 cycle.
2. mode_vld with mode=01 -> next edge led_out=FE, cnt=0. After 25 clocks 7F, then BF.
3. mode=10 -> FE, FD ... 7F, BF ... FE. 7F and FE each appear once per pass; period 14 steps (350 clocks).
4. mode=11 -> 00, FF, 00 at 25-clock spacing.
5. pause=1 at cnt=10 for 100 clocks -> no led_out change, no step_pulse. Release -> step exactly 15 clocks later. Then mode_vld during pause -> mode load applies; pattern resets to FE.
6. mode_vld on a tick cycle -> no step, pattern reset. sys_rst_n=0 for one clock mid-BOUNCE -> led_out=FE, state LEFT.
7. (with LED_FLOW_DIM_EN) duty=4 -> each lit LED low 4 of 16 clocks.
